// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: stack/sign enums, default widths and the spill depth.
`ifndef EJ32_DEFS_SV
`define EJ32_DEFS_SV
`define SSZ 6
`define DSZ 32
`define SU logic [`SSZ-1:0]
`define DU logic [`DSZ-1:0]
`endif

package ej32_pkg;

    typedef enum logic [1:0] {
        sNOP  = 2'd0,
        sPUSH = 2'd1,
        sMOVE = 2'd2,
        sPOP  = 2'd3
    } stack_op;

    typedef enum logic [1:0] {
        tEQ = 2'd0,
        tGT = 2'd1,
        tGE = 2'd2,
        tLT = 2'd3
    } tos_sign;

    localparam int DEF_SSZ = `SSZ;
    localparam int DEF_DSZ = `DSZ;
    localparam int SDEPTH  = 2**`SSZ;

endpackage

// File: rtl/ej32_dstack_if.sv
// Bundle between the decode/execute stage (master) and the data stack (slave).
interface ej32_dstack_if
    import ej32_pkg::*;
#(
    parameter int SSZ = DEF_SSZ,
    parameter int DSZ = DEF_DSZ
) ();

    stack_op        op;
    logic           t_we;
    logic [DSZ-1:0] t_in;
    logic           clr_err;
    logic [DSZ-1:0] t;
    logic [DSZ-1:0] s;
    logic [SSZ-1:0] sp;
    tos_sign        t_sgn;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           udf;

    modport master (
        output op, t_we, t_in, clr_err,
        input  t, s, sp, t_sgn, empty, full, ovf, udf
    );

    modport slave (
        input  op, t_we, t_in, clr_err,
        output t, s, sp, t_sgn, empty, full, ovf, udf
    );

endinterface

// File: rtl/ej32_spram.sv
// Spill array: one synchronous write port, one asynchronous read port.
module ej32_spram
    import ej32_pkg::*;
#(
    parameter int AW = DEF_SSZ,
    parameter int DW = DEF_DSZ
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array is deliberately not reset; a reset would block distributed-RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ej32_dstack.sv
// eJ32 data stack: TOS/NOS registers, spill array below them, sticky overflow/underflow flags.
module ej32_dstack
    import ej32_pkg::*;
#(
    parameter int SSZ = DEF_SSZ,
    parameter int DSZ = DEF_DSZ
) (
    input logic          clk,
    input logic          rst,
    ej32_dstack_if.slave bus
);

    localparam logic [SSZ-1:0] SP_ONE = SSZ'(1);

    logic [DSZ-1:0] t_q;
    logic [DSZ-1:0] s_q;
    logic [DSZ-1:0] spill_rd;
    logic [SSZ-1:0] sp_q;
    logic           ovf_q;
    logic           udf_q;
    logic           is_empty;
    logic           is_full;
    logic           push_ok;
    logic           ovf_hit;
    logic           udf_hit;
    tos_sign        sign;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == '1);
    assign push_ok  = (bus.op == sPUSH) && !is_full;
    assign ovf_hit  = (bus.op == sPUSH) && is_full;
    assign udf_hit  = (bus.op == sPOP)  && is_empty;

    // Read address sp-1 is combinational, so a pop right after a push sees the fresh spill.
    ej32_spram #(.AW(SSZ), .DW(DSZ)) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (sp_q),
        .wdata (s_q),
        .raddr (sp_q - SP_ONE),
        .rdata (spill_rd)
    );

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_q   <= '0;
            s_q   <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            case (bus.op)
                sNOP: begin
                    if (bus.t_we) t_q <= bus.t_in;
                end
                sPUSH: begin
                    if (!is_full) begin
                        s_q  <= t_q;
                        t_q  <= bus.t_in;
                        sp_q <= sp_q + SP_ONE;
                    end
                end
                sMOVE: begin
                    s_q <= t_q;
                    t_q <= bus.t_in;
                end
                sPOP: begin
                    t_q <= bus.t_in;
                    if (is_empty) begin
                        s_q <= '0;
                    end else begin
                        s_q  <= spill_rd;
                        sp_q <= sp_q - SP_ONE;
                    end
                end
                default: ;
            endcase
            // A new error wins over a simultaneous clear.
            ovf_q <= ovf_hit | (ovf_q & ~bus.clr_err);
            udf_q <= udf_hit | (udf_q & ~bus.clr_err);
        end
    end

    // NOTE: the default assignment first keeps this always_comb from inferring a latch.
    always_comb begin
        sign = tGT;
        if (t_q == '0)          sign = tEQ;
        else if (t_q[DSZ-1])    sign = tLT;
    end

    assign bus.t     = t_q;
    assign bus.s     = s_q;
    assign bus.sp    = sp_q;
    assign bus.t_sgn = sign;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule

// File: tb/tb_ej32_dstack.sv
// Self-checking bench for ej32_dstack: directed scenarios plus a randomized run against a queue model.
module tb_ej32_dstack;
    import ej32_pkg::*;

    localparam int MAXSP = SDEPTH - 1;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ej32_dstack_if #(.SSZ(DEF_SSZ), .DSZ(DEF_DSZ)) bus ();

    ej32_dstack #(.SSZ(DEF_SSZ), .DSZ(DEF_DSZ)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Reference model: TOS, NOS and the spill array as a queue (back = deepest-most-recent).
    logic [31:0] m_t;
    logic [31:0] m_s;
    logic [31:0] m_q[$];
    logic        m_ovf;
    logic        m_udf;

    function automatic tos_sign exp_sign(input logic [31:0] v);
        if (v == 32'd0) return tEQ;
        if (v >= 32'h8000_0000) return tLT;
        return tGT;
    endfunction

    task automatic model_reset();
        m_t = '0;
        m_s = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_op(input stack_op o, input logic we, input logic [31:0] v, input logic clr);
        logic oset;
        logic uset;
        oset = 1'b0;
        uset = 1'b0;
        case (o)
            sNOP:  if (we) m_t = v;
            sPUSH: begin
                if (m_q.size() == MAXSP) oset = 1'b1;
                else begin
                    m_q.push_back(m_s);
                    m_s = m_t;
                    m_t = v;
                end
            end
            sMOVE: begin
                m_s = m_t;
                m_t = v;
            end
            default: begin
                m_t = v;
                if (m_q.size() == 0) begin
                    m_s = '0;
                    uset = 1'b1;
                end else begin
                    m_s = m_q.pop_back();
                end
            end
        endcase
        m_ovf = oset | (m_ovf & ~clr);
        m_udf = uset | (m_udf & ~clr);
    endtask

    task automatic set_idle();
        bus.op      = sNOP;
        bus.t_we    = 1'b0;
        bus.t_in    = '0;
        bus.clr_err = 1'b0;
    endtask

    // Drive one op for one clock, then sample 1 time unit after the edge.
    task automatic step(input stack_op o, input logic we, input logic [31:0] v, input logic clr);
        bus.op      = o;
        bus.t_we    = we;
        bus.t_in    = v;
        bus.clr_err = clr;
        @(posedge clk);
        #1;
        model_op(o, we, v, clr);
        set_idle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        model_reset();
        #12;
        tests++; if (bus.t !== 32'd0) begin fails++; $display("FAIL reset_t: got %0h want 0", bus.t); end
        @(negedge clk);
        rst = 1'b1;
        step(sPOP, 1'b0, 32'h33, 1'b0);
        tests++; if (bus.udf !== 1'b1) begin fails++; $display("FAIL pre_reset_udf: got %0b want 1", bus.udf); end
        step(sPUSH, 1'b0, 32'h5, 1'b0);
        step(sPUSH, 1'b0, 32'h6, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        tests++; if (bus.t !== 32'd0) begin fails++; $display("FAIL async_t: got %0h want 0", bus.t); end
        tests++; if (bus.s !== 32'd0) begin fails++; $display("FAIL async_s: got %0h want 0", bus.s); end
        tests++; if (bus.sp !== 6'd0) begin fails++; $display("FAIL async_sp: got %0d want 0", bus.sp); end
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL async_empty: got %0b want 1", bus.empty); end
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL async_full: got %0b want 0", bus.full); end
        tests++; if (bus.t_sgn !== tEQ) begin fails++; $display("FAIL async_sgn: got %0d want %0d", bus.t_sgn, tEQ); end
        tests++; if (bus.ovf !== 1'b0 || bus.udf !== 1'b0) begin fails++; $display("FAIL async_flags: got %0b%0b want 00", bus.ovf, bus.udf); end
        @(negedge clk);
        rst = 1'b1;
        step(sPUSH, 1'b0, 32'h11, 1'b0);
        tests++; if (bus.t !== 32'h11 || bus.sp !== 6'd1) begin fails++; $display("FAIL first_op: got t=%0h sp=%0d want t=11 sp=1", bus.t, bus.sp); end
    endtask

    task automatic test_push_sign();
        do_reset();
        step(sPUSH, 1'b0, 32'd1, 1'b0);
        step(sPUSH, 1'b0, 32'd2, 1'b0);
        step(sPUSH, 1'b0, 32'd3, 1'b0);
        tests++; if (bus.t !== 32'd3) begin fails++; $display("FAIL push_t: got %0h want 3", bus.t); end
        tests++; if (bus.s !== 32'd2) begin fails++; $display("FAIL push_s: got %0h want 2", bus.s); end
        tests++; if (bus.sp !== 6'd3) begin fails++; $display("FAIL push_sp: got %0d want 3", bus.sp); end
        tests++; if (u_dut.u_ram.mem[2] !== 32'd1) begin fails++; $display("FAIL push_mem2: got %0h want 1", u_dut.u_ram.mem[2]); end
        tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL push_empty: got %0b want 0", bus.empty); end

        step(sMOVE, 1'b0, 32'd2, 1'b0);
        tests++; if (bus.t !== 32'd2 || bus.s !== 32'd3) begin fails++; $display("FAIL swap_ts: got t=%0h s=%0h want t=2 s=3", bus.t, bus.s); end
        tests++; if (bus.sp !== 6'd3) begin fails++; $display("FAIL swap_sp: got %0d want 3", bus.sp); end

        step(sNOP, 1'b0, 32'hABCD, 1'b0);
        tests++; if (bus.t !== 32'd2) begin fails++; $display("FAIL nop_no_we: got %0h want 2", bus.t); end

        step(sNOP, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tests++; if (bus.t_sgn !== tLT) begin fails++; $display("FAIL sign_lt: got %0d want %0d", bus.t_sgn, tLT); end
        tests++; if (bus.s !== 32'd3 || bus.sp !== 6'd3) begin fails++; $display("FAIL nop_keep: got s=%0h sp=%0d want s=3 sp=3", bus.s, bus.sp); end
        step(sNOP, 1'b1, 32'd5, 1'b0);
        tests++; if (bus.t_sgn !== tGT) begin fails++; $display("FAIL sign_gt: got %0d want %0d", bus.t_sgn, tGT); end
        step(sNOP, 1'b1, 32'd0, 1'b0);
        tests++; if (bus.t_sgn !== tEQ) begin fails++; $display("FAIL sign_eq: got %0d want %0d", bus.t_sgn, tEQ); end
        step(sNOP, 1'b1, 32'h8000_0000, 1'b0);
        tests++; if (bus.t_sgn !== tLT) begin fails++; $display("FAIL sign_msb: got %0d want %0d", bus.t_sgn, tLT); end
        step(sNOP, 1'b1, 32'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        // From t=5, s=3, sp=3: push then pop with no idle cycle between.
        step(sPUSH, 1'b0, 32'd7, 1'b0);
        tests++; if (bus.t !== 32'd7 || bus.s !== 32'd5 || bus.sp !== 6'd4) begin fails++; $display("FAIL b2b_push: got t=%0h s=%0h sp=%0d want 7 5 4", bus.t, bus.s, bus.sp); end
        step(sPOP, 1'b0, 32'd9, 1'b0);
        tests++; if (bus.t !== 32'd9) begin fails++; $display("FAIL b2b_pop_t: got %0h want 9", bus.t); end
        tests++; if (bus.s !== 32'd3) begin fails++; $display("FAIL b2b_pop_s: got %0h want 3", bus.s); end
        tests++; if (bus.sp !== 6'd3) begin fails++; $display("FAIL b2b_pop_sp: got %0d want 3", bus.sp); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < MAXSP; i++) step(sPUSH, 1'b0, 32'd100 + 32'(i), 1'b0);
        tests++; if (bus.sp !== 6'd63 || bus.full !== 1'b1) begin fails++; $display("FAIL fill: got sp=%0d full=%0b want 63 1", bus.sp, bus.full); end
        tests++; if (bus.t !== 32'd162 || bus.s !== 32'd161) begin fails++; $display("FAIL fill_ts: got t=%0d s=%0d want 162 161", bus.t, bus.s); end
        step(sPUSH, 1'b0, 32'hDEAD, 1'b0);
        tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0b want 1", bus.ovf); end
        tests++; if (bus.t !== 32'd162 || bus.s !== 32'd161 || bus.sp !== 6'd63) begin fails++; $display("FAIL ovf_hold: got t=%0d s=%0d sp=%0d want 162 161 63", bus.t, bus.s, bus.sp); end
        step(sNOP, 1'b0, 32'd0, 1'b1);
        tests++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %0b want 0", bus.ovf); end
        step(sPUSH, 1'b0, 32'hBEEF, 1'b1);
        tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_prio: got %0b want 1", bus.ovf); end
        step(sNOP, 1'b0, 32'd0, 1'b0);
        tests++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b want 1", bus.ovf); end
        for (int i = 0; i < MAXSP; i++) begin
            step(sPOP, 1'b0, 32'(i), 1'b0);
            tests++; if (bus.s !== m_s || bus.sp !== 6'(m_q.size())) begin fails++; $display("FAIL drain_%0d: got s=%0d sp=%0d want s=%0d sp=%0d", i, bus.s, bus.sp, m_s, m_q.size()); end
        end
        tests++; if (bus.udf !== 1'b0 || bus.empty !== 1'b1) begin fails++; $display("FAIL drain_end: got udf=%0b empty=%0b want 0 1", bus.udf, bus.empty); end
    endtask

    task automatic test_underflow();
        step(sPOP, 1'b0, 32'd4, 1'b0);
        tests++; if (bus.t !== 32'd4 || bus.s !== 32'd0 || bus.sp !== 6'd0) begin fails++; $display("FAIL udf_state: got t=%0h s=%0h sp=%0d want 4 0 0", bus.t, bus.s, bus.sp); end
        tests++; if (bus.udf !== 1'b1) begin fails++; $display("FAIL udf_set: got %0b want 1", bus.udf); end
        step(sPOP, 1'b0, 32'd8, 1'b1);
        tests++; if (bus.udf !== 1'b1) begin fails++; $display("FAIL udf_prio: got %0b want 1", bus.udf); end
        step(sNOP, 1'b0, 32'd0, 1'b1);
        tests++; if (bus.udf !== 1'b0) begin fails++; $display("FAIL udf_clr: got %0b want 0", bus.udf); end
    endtask

    task automatic test_random();
        stack_op     o;
        logic        we;
        logic        clr;
        logic [31:0] v;
        int          r;
        int          nerr;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 42)      o = sPUSH;
            else if (r < 70) o = sPOP;
            else if (r < 85) o = sMOVE;
            else             o = sNOP;
            we  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 9) == 0);
            r   = int'($urandom_range(0, 7));
            if (r == 0)      v = 32'd0;
            else if (r == 1) v = $urandom | 32'h8000_0000;
            else             v = $urandom;
            step(o, we, v, clr);
            nerr = 0;
            tests++;
            if (bus.t !== m_t || bus.s !== m_s || bus.sp !== 6'(m_q.size())) nerr++;
            if (bus.t_sgn !== exp_sign(m_t)) nerr++;
            if (bus.empty !== (m_q.size() == 0) || bus.full !== (m_q.size() == MAXSP)) nerr++;
            if (bus.ovf !== m_ovf || bus.udf !== m_udf) nerr++;
            if (nerr != 0) begin
                fails++;
                if (fails < 20)
                    $display("FAIL rand_%0d: got t=%0h s=%0h sp=%0d sgn=%0d e=%0b f=%0b o=%0b u=%0b want t=%0h s=%0h sp=%0d sgn=%0d o=%0b u=%0b",
                             i, bus.t, bus.s, bus.sp, bus.t_sgn, bus.empty, bus.full, bus.ovf, bus.udf,
                             m_t, m_s, m_q.size(), exp_sign(m_t), m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_push_sign();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
